// File: rtl/generate_instruction.sv
// DDR4 FCFS command generator: issues NOP/PRE/ACT/RD/WR for the FIFO head request.
// Latency: command/pop are combinational (Mealy) from registered bank state; state updates at the next edge.
// Backpressure: waits with NOP until the bank's timing countdowns allow; pops only with the completing RD/WR.
module generate_instruction #(
    parameter int T_RCD   = 4,
    parameter int T_RP    = 4,
    parameter int T_RAS   = 10,
    parameter int T_RTP   = 3,
    parameter int T_WR    = 5,
    parameter int T_RRD_S = 2,
    parameter int T_RRD_L = 3,
    parameter int T_CCD_S = 2,
    parameter int T_CCD_L = 3,
    parameter int T_RTW   = 4,
    parameter int T_WTR   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        r_w,
    input  logic [31:0] write_data,
    input  logic        fifo_empty,
    output logic        pop,
    output logic [2:0]  command
);

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_PRE = 3'd1,
        CMD_ACT = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4
    } cmd_e;

    typedef struct packed {
        logic        is_open;
        logic [13:0] open_row;
        logic [5:0]  t_can_pre;
        logic [5:0]  t_can_act;
        logic [5:0]  t_can_rd;
        logic [5:0]  t_can_wr;
    } bank_t;

    // A constraint of N cycles loads N-1 so the dependent command is legal in cycle k+N.
    localparam logic [5:0] L_RCD   = 6'(T_RCD - 1);
    localparam logic [5:0] L_RP    = 6'(T_RP - 1);
    localparam logic [5:0] L_RAS   = 6'(T_RAS - 1);
    localparam logic [5:0] L_RTP   = 6'(T_RTP - 1);
    localparam logic [5:0] L_WR    = 6'(T_WR - 1);
    localparam logic [5:0] L_RRD_S = 6'(T_RRD_S - 1);
    localparam logic [5:0] L_RRD_L = 6'(T_RRD_L - 1);
    localparam logic [5:0] L_CCD_S = 6'(T_CCD_S - 1);
    localparam logic [5:0] L_CCD_L = 6'(T_CCD_L - 1);
    localparam logic [5:0] L_RTW   = 6'(T_RTW - 1);
    localparam logic [5:0] L_WTR   = 6'(T_WTR - 1);

    bank_t bank_info [0:15];
    bank_t bank_next [0:15];

    logic [13:0] req_row;
    logic [1:0]  req_bg;
    logic [3:0]  req_bank;
    bank_t       head;
    cmd_e        cmd;

    // Column, write data and spare address bits do not affect command selection.
    logic unused_bits;
    assign unused_bits = ^{write_data, address[31:30], address[11:0]};

    assign req_row  = address[29:16];
    assign req_bg   = address[15:14];
    assign req_bank = address[15:12];
    assign head     = bank_info[req_bank];
    assign command  = cmd;

    // Saturating decrement, then take the larger of that and any new load.
    function automatic logic [5:0] dec_max(input logic [5:0] cnt, input logic [5:0] load);
        logic [5:0] d;
        d = (cnt == 6'd0) ? 6'd0 : cnt - 6'd1;
        return (d > load) ? d : load;
    endfunction

    // Pick the single command for the head request from its bank's state.
    always_comb begin
        cmd = CMD_NOP;
        pop = 1'b0;
        if (!reset && !fifo_empty) begin
            if (!head.is_open) begin
                if (head.t_can_act == 6'd0) cmd = CMD_ACT;
            end else if (head.open_row != req_row) begin
                if (head.t_can_pre == 6'd0) cmd = CMD_PRE;
            end else if (!r_w) begin
                if (head.t_can_rd == 6'd0) begin
                    cmd = CMD_RD;
                    pop = 1'b1;
                end
            end else begin
                if (head.t_can_wr == 6'd0) begin
                    cmd = CMD_WR;
                    pop = 1'b1;
                end
            end
        end
    end

    // Next bank state: apply the issued command's row effect and timing loads to every bank.
    always_comb begin
        logic [3:0] idx;
        logic       same_bank;
        logic       same_bg;
        logic [5:0] ld_pre;
        logic [5:0] ld_act;
        logic [5:0] ld_rd;
        logic [5:0] ld_wr;
        bank_t      nxt;
        for (int i = 0; i < 16; i++) begin
            idx       = 4'(i);
            same_bank = (idx == req_bank);
            same_bg   = (idx[3:2] == req_bg);
            ld_pre    = 6'd0;
            ld_act    = 6'd0;
            ld_rd     = 6'd0;
            ld_wr     = 6'd0;
            nxt       = bank_info[i];
            case (cmd)
                CMD_ACT: begin
                    if (same_bank) begin
                        nxt.is_open  = 1'b1;
                        nxt.open_row = req_row;
                        ld_rd        = L_RCD;
                        ld_wr        = L_RCD;
                        ld_pre       = L_RAS;
                    end else begin
                        ld_act = same_bg ? L_RRD_L : L_RRD_S;
                    end
                end
                CMD_PRE: begin
                    if (same_bank) begin
                        nxt.is_open = 1'b0;
                        ld_act      = L_RP;
                    end
                end
                CMD_RD: begin
                    if (same_bank) ld_pre = L_RTP;
                    ld_rd = same_bg ? L_CCD_L : L_CCD_S;
                    ld_wr = L_RTW;
                end
                CMD_WR: begin
                    if (same_bank) ld_pre = L_WR;
                    ld_wr = same_bg ? L_CCD_L : L_CCD_S;
                    ld_rd = L_WTR;
                end
                default: ;
            endcase
            nxt.t_can_pre = dec_max(bank_info[i].t_can_pre, ld_pre);
            nxt.t_can_act = dec_max(bank_info[i].t_can_act, ld_act);
            nxt.t_can_rd  = dec_max(bank_info[i].t_can_rd, ld_rd);
            nxt.t_can_wr  = dec_max(bank_info[i].t_can_wr, ld_wr);
            bank_next[i]  = nxt;
        end
    end

    // Bank state register; reset closes every bank and clears all countdowns.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (reset) bank_info[i] <= '0;
            else       bank_info[i] <= bank_next[i];
        end
    end

endmodule

// File: tb/tb_generate_instruction.sv
// Directed bench for generate_instruction: per-cycle command/pop sequences against hand-derived tables.
// Inputs change 1ns after the rising edge; outputs are compared 2ns after the edge.
// Bank state is probed hierarchically after the edge that applies it.
module tb_generate_instruction;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        r_w;
    logic [31:0] write_data;
    logic        fifo_empty;
    logic        pop;
    logic [2:0]  command;

    int checks;
    int errors;

    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] PRE = 3'd1;
    localparam logic [2:0] ACT = 3'd2;
    localparam logic [2:0] RD  = 3'd3;
    localparam logic [2:0] WR  = 3'd4;

    generate_instruction dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .r_w        (r_w),
        .write_data (write_data),
        .fifo_empty (fifo_empty),
        .pop        (pop),
        .command    (command)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_addr(input logic [13:0] row, input logic [1:0] bg,
                                            input logic [1:0] bk, input logic [7:0] col);
        return {2'b00, row, bg, bk, col, 4'h0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        fifo_empty = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        fifo_empty = 1'b0;
        r_w        = 1'b0;
        address    = mk_addr(14'h0001, 2'd0, 2'd0, 8'h00);
        #1;
        checks++;
        if (command !== NOP || pop !== 1'b0) begin
            errors++;
            $display("FAIL reset_out command=%0d pop=%0b expected command=0 pop=0", command, pop);
        end
        step();
        step();
        checks++;
        if (dut.bank_info[0] !== '0) begin
            errors++;
            $display("FAIL reset_bank0 bank_info[0]=%h expected 0", dut.bank_info[0]);
        end
        reset      = 1'b0;
        fifo_empty = 1'b1;
    endtask

    task automatic test_closed_read();
        logic [2:0] exp [0:4] = '{ACT, NOP, NOP, NOP, RD};
        address    = mk_addr(14'h1234, 2'd0, 2'd0, 8'h10);
        r_w        = 1'b0;
        fifo_empty = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (command !== exp[c] || pop !== (c == 4)) begin
                errors++;
                $display("FAIL closed_read cyc %0d command=%0d pop=%0b expected command=%0d pop=%0b",
                         c, command, pop, exp[c], (c == 4));
            end
            step();
        end
        fifo_empty = 1'b1;
        checks++;
        if (dut.bank_info[0].is_open !== 1'b1 || dut.bank_info[0].open_row !== 14'h1234) begin
            errors++;
            $display("FAIL closed_read_state is_open=%0b open_row=%h expected 1 1234",
                     dut.bank_info[0].is_open, dut.bank_info[0].open_row);
        end
    endtask

    task automatic test_row_hit();
        repeat (3) step();
        address    = mk_addr(14'h1234, 2'd0, 2'd0, 8'h20);
        r_w        = 1'b0;
        fifo_empty = 1'b0;
        #1;
        checks++;
        if (command !== RD || pop !== 1'b1) begin
            errors++;
            $display("FAIL row_hit command=%0d pop=%0b expected command=3 pop=1", command, pop);
        end
        step();
        fifo_empty = 1'b1;
    endtask

    task automatic test_row_miss();
        logic [2:0] exp [0:8] = '{PRE, NOP, NOP, NOP, ACT, NOP, NOP, NOP, RD};
        repeat (3) step();
        address    = mk_addr(14'h1678, 2'd0, 2'd0, 8'h00);
        r_w        = 1'b0;
        fifo_empty = 1'b0;
        for (int c = 0; c < 9; c++) begin
            #1;
            checks++;
            if (command !== exp[c] || pop !== (c == 8)) begin
                errors++;
                $display("FAIL row_miss cyc %0d command=%0d pop=%0b expected command=%0d pop=%0b",
                         c, command, pop, exp[c], (c == 8));
            end
            step();
        end
        fifo_empty = 1'b1;
        checks++;
        if (dut.bank_info[0].open_row !== 14'h1678) begin
            errors++;
            $display("FAIL row_miss_state open_row=%h expected 1678", dut.bank_info[0].open_row);
        end
    endtask

    // ACT spacing to a bank in the same group (tRRD_L=3) and another group (tRRD_S=2).
    task automatic test_rrd();
        logic [2:0] exp_l [1:3] = '{NOP, NOP, ACT};
        logic [2:0] exp_s [1:2] = '{NOP, ACT};
        do_reset();
        address    = mk_addr(14'h0010, 2'd0, 2'd0, 8'h00);
        r_w        = 1'b0;
        fifo_empty = 1'b0;
        #1;
        checks++;
        if (command !== ACT) begin
            errors++;
            $display("FAIL rrd_first_act command=%0d expected 2", command);
        end
        step();
        address = mk_addr(14'h0010, 2'd0, 2'd1, 8'h00);
        for (int c = 1; c < 4; c++) begin
            #1;
            checks++;
            if (command !== exp_l[c]) begin
                errors++;
                $display("FAIL rrd_l cyc %0d command=%0d expected %0d", c, command, exp_l[c]);
            end
            step();
        end
        do_reset();
        address    = mk_addr(14'h0010, 2'd0, 2'd0, 8'h00);
        fifo_empty = 1'b0;
        step();
        address = mk_addr(14'h0010, 2'd1, 2'd0, 8'h00);
        for (int c = 1; c < 3; c++) begin
            #1;
            checks++;
            if (command !== exp_s[c]) begin
                errors++;
                $display("FAIL rrd_s cyc %0d command=%0d expected %0d", c, command, exp_s[c]);
            end
            step();
        end
        fifo_empty = 1'b1;
    endtask

    // Row miss right after ACT must wait for tRAS=10 before PRE.
    task automatic test_tras();
        do_reset();
        address    = mk_addr(14'h1234, 2'd0, 2'd0, 8'h00);
        r_w        = 1'b0;
        fifo_empty = 1'b0;
        step();
        address = mk_addr(14'h0abc, 2'd0, 2'd0, 8'h00);
        for (int c = 1; c < 11; c++) begin
            #1;
            checks++;
            if (command !== ((c == 10) ? PRE : NOP)) begin
                errors++;
                $display("FAIL tras cyc %0d command=%0d expected %0d", c, command, (c == 10) ? PRE : NOP);
            end
            step();
        end
        fifo_empty = 1'b1;
    endtask

    // RD -> WR (tRTW=4) then WR -> RD (tWTR=3), all on bank 0 row hits.
    task automatic test_back_to_back();
        logic [2:0] exp [0:11] = '{ACT, NOP, NOP, NOP, RD, NOP, NOP, NOP, WR, NOP, NOP, RD};
        logic       rw  [0:11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        logic       ep;
        do_reset();
        address    = mk_addr(14'h1234, 2'd0, 2'd0, 8'h00);
        write_data = 32'hdead_beef;
        fifo_empty = 1'b0;
        for (int c = 0; c < 12; c++) begin
            r_w = rw[c];
            ep  = (c == 4) || (c == 8) || (c == 11);
            #1;
            checks++;
            if (command !== exp[c] || pop !== ep) begin
                errors++;
                $display("FAIL back_to_back cyc %0d command=%0d pop=%0b expected command=%0d pop=%0b",
                         c, command, pop, exp[c], ep);
            end
            step();
        end
    endtask

    // Reset in the middle of traffic abandons all bank state; next request reopens with ACT.
    task automatic test_mid_reset();
        address    = mk_addr(14'h0022, 2'd1, 2'd1, 8'h00);
        r_w        = 1'b0;
        fifo_empty = 1'b0;
        step();
        reset = 1'b1;
        #1;
        checks++;
        if (command !== NOP || pop !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_out command=%0d pop=%0b expected command=0 pop=0", command, pop);
        end
        step();
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (dut.bank_info[b] !== '0) begin
                errors++;
                $display("FAIL mid_reset_bank %0d bank_info=%h expected 0", b, dut.bank_info[b]);
            end
        end
        reset   = 1'b0;
        address = mk_addr(14'h1234, 2'd0, 2'd0, 8'h00);
        #1;
        checks++;
        if (command !== ACT || pop !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_reopen command=%0d pop=%0b expected command=2 pop=0", command, pop);
        end
        step();
    endtask

    // An empty FIFO yields NOP even when the address would be a row hit.
    task automatic test_empty();
        repeat (4) step();
        fifo_empty = 1'b1;
        #1;
        checks++;
        if (command !== NOP || pop !== 1'b0) begin
            errors++;
            $display("FAIL empty command=%0d pop=%0b expected command=0 pop=0", command, pop);
        end
        step();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        address    = '0;
        r_w        = 1'b0;
        write_data = '0;
        fifo_empty = 1'b1;
        #1;
        test_reset();
        test_closed_read();
        test_row_hit();
        test_row_miss();
        test_rrd();
        test_tras();
        test_back_to_back();
        test_mid_reset();
        test_empty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
